// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus arbiter: sequencer state encoding,
// requester indices and the default wait-state limit.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int REQ_FETCH = 0;
  localparam int REQ_LS    = 1;
  localparam int REQ_EXT   = 2;

  localparam int WAIT_MAX_DEFAULT = 15;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request scanning last+1, last+2, ...
// modulo NREQ. Returns the one-hot winner, its binary index and an any-request flag.
module rr_pick #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      last,
  output logic [NREQ-1:0] win,
  output logic [2:0]      win_id,
  output logic            any_req
);

  int              idx;
  logic [NREQ-1:0] req_sh;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    win     = '0;
    win_id  = '0;
    any_req = 1'b0;
    idx     = 0;
    req_sh  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx    = (int'(last) + i) % NREQ;
      req_sh = req >> idx;
      if (!any_req && req_sh[0]) begin
        any_req = 1'b1;
        win_id  = 3'(idx);
      end
    end
    if (any_req) win = NREQ'(1) << win_id;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter and access sequencer for the shared memory bus.
// Optional wait-state timeout (bus error) is enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic [NREQ-1:0]   REQ,
  input  logic [NREQ-1:0]   REQ_WR,
  input  logic [NREQ*AW-1:0] REQ_ADDR,
  input  logic [NREQ*DW-1:0] REQ_WDATA,
  output logic [NREQ-1:0]   GNT,
  output logic [NREQ-1:0]   ACK,
  output logic              ERR,
  output logic [DW-1:0]     RDATA,
  output logic [2:0]        GNT_ID,
  output logic [AW-1:0]     MEM_ADDR,
  output logic [DW-1:0]     MEM_DOUT,
  output logic              MEM_RD,
  output logic              MEM_WR,
  input  logic [DW-1:0]     MEM_DIN,
  input  logic              MEM_READY
);

  state_t          state, state_nxt;
  logic [2:0]      last, last_nxt;
  logic [NREQ-1:0] gnt_nxt, ack_nxt, pick_oh;
  logic [2:0]      gnt_id_nxt, pick_id;
  logic            any_req;
  logic [AW-1:0]   addr_nxt, sel_addr;
  logic [DW-1:0]   dout_nxt, rdata_nxt, sel_wdata;
  logic            rd_nxt, wr_nxt, sel_wr;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int CW = $clog2(WAIT_MAX + 1);
  logic [CW-1:0] cnt, cnt_nxt;
  logic          err_q, err_nxt;
  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (REQ),
    .last    (last),
    .win     (pick_oh),
    .win_id  (pick_id),
    .any_req (any_req)
  );

  assign sel_wr    = |(REQ_WR & pick_oh);
  assign sel_addr  = AW'(REQ_ADDR >> (AW * int'(pick_id)));
  assign sel_wdata = DW'(REQ_WDATA >> (DW * int'(pick_id)));

  always_comb begin
    state_nxt  = state;
    last_nxt   = last;
    gnt_nxt    = GNT;
    gnt_id_nxt = GNT_ID;
    ack_nxt    = ACK;
    addr_nxt   = MEM_ADDR;
    dout_nxt   = MEM_DOUT;
    rd_nxt     = MEM_RD;
    wr_nxt     = MEM_WR;
    rdata_nxt  = RDATA;
`ifdef MEM_BUS_TIMEOUT_EN
    cnt_nxt    = cnt;
    err_nxt    = err_q;
`endif
    case (state)
      ST_IDLE: begin
        rd_nxt = 1'b0;
        wr_nxt = 1'b0;
        if (any_req) begin
          gnt_nxt    = pick_oh;
          gnt_id_nxt = pick_id;
          last_nxt   = pick_id;
          addr_nxt   = sel_addr;
          dout_nxt   = sel_wdata;
          rd_nxt     = ~sel_wr;
          wr_nxt     = sel_wr;
          state_nxt  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (MEM_READY) begin
          rdata_nxt = MEM_WR ? '0 : MEM_DIN;
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          ack_nxt   = GNT;
          state_nxt = ST_DONE;
        end
`ifdef MEM_BUS_TIMEOUT_EN
        // READY in the same cycle the limit is hit wins over the timeout.
        else if (cnt == CW'(WAIT_MAX)) begin
          rdata_nxt = '0;
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          ack_nxt   = GNT;
          err_nxt   = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
`endif
      end
      ST_DONE: begin
        gnt_nxt   = '0;
        ack_nxt   = '0;
        state_nxt = ST_IDLE;
`ifdef MEM_BUS_TIMEOUT_EN
        cnt_nxt   = '0;
        err_nxt   = 1'b0;
`endif
      end
      default: begin
        gnt_nxt   = '0;
        ack_nxt   = '0;
        rd_nxt    = 1'b0;
        wr_nxt    = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) begin
      state    <= ST_IDLE;
      last     <= 3'(NREQ - 1);
      GNT      <= '0;
      GNT_ID   <= '0;
      ACK      <= '0;
      RDATA    <= '0;
      MEM_ADDR <= '0;
      MEM_DOUT <= '0;
      MEM_RD   <= 1'b0;
      MEM_WR   <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
      cnt      <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      GNT      <= gnt_nxt;
      GNT_ID   <= gnt_id_nxt;
      ACK      <= ack_nxt;
      RDATA    <= rdata_nxt;
      MEM_ADDR <= addr_nxt;
      MEM_DOUT <= dout_nxt;
      MEM_RD   <= rd_nxt;
      MEM_WR   <= wr_nxt;
`ifdef MEM_BUS_TIMEOUT_EN
      cnt      <= cnt_nxt;
      err_q    <= err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed cases plus randomized transactions
// compared against a transaction-level round-robin model.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = 16;
  localparam int DW   = 16;

  logic               CLK = 1'b0;
  logic               RESETN;
  logic [NREQ-1:0]    REQ, REQ_WR;
  logic [NREQ*AW-1:0] REQ_ADDR;
  logic [NREQ*DW-1:0] REQ_WDATA;
  logic [NREQ-1:0]    GNT, ACK;
  logic               ERR;
  logic [DW-1:0]      RDATA, MEM_DOUT, MEM_DIN;
  logic [2:0]         GNT_ID;
  logic [AW-1:0]      MEM_ADDR;
  logic               MEM_RD, MEM_WR, MEM_READY;

  mem_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .REQ       (REQ),
    .REQ_WR    (REQ_WR),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .GNT       (GNT),
    .ACK       (ACK),
    .ERR       (ERR),
    .RDATA     (RDATA),
    .GNT_ID    (GNT_ID),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_DOUT  (MEM_DOUT),
    .MEM_RD    (MEM_RD),
    .MEM_WR    (MEM_WR),
    .MEM_DIN   (MEM_DIN),
    .MEM_READY (MEM_READY)
  );

  always #5 CLK = ~CLK;

  int            n_vec = 0;
  int            n_err = 0;
  logic [AW-1:0] addr_a  [NREQ];
  logic [DW-1:0] wdata_a [NREQ];
  logic          wr_a    [NREQ];
  // Rotation order: next candidate first; the winner is rotated to the back.
  int            rr_q[$];
  int            n_to;
  logic          seen_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    rr_q.delete();
    for (int i = 0; i < NREQ; i++) rr_q.push_back(i);
  endfunction

  function automatic int model_pick(input logic [NREQ-1:0] r);
    int w;
    int h;
    logic [NREQ-1:0] sh;
    w = -1;
    foreach (rr_q[k]) begin
      sh = r >> rr_q[k];
      if (w < 0 && sh[0]) w = rr_q[k];
    end
    if (w >= 0) begin
      do begin
        h = rr_q.pop_front();
        rr_q.push_back(h);
      end while (h != w);
    end
    return w;
  endfunction

  task automatic drive_reqs(input logic [NREQ-1:0] reqv);
    logic [NREQ*AW-1:0] a;
    logic [NREQ*DW-1:0] d;
    a = '0;
    d = '0;
    for (int i = 0; i < NREQ; i++) begin
      a |= (NREQ*AW)'(addr_a[i]) << (AW * i);
      d |= (NREQ*DW)'(wdata_a[i]) << (DW * i);
      REQ_WR[i] = wr_a[i];
    end
    REQ_ADDR  = a;
    REQ_WDATA = d;
    REQ       = reqv;
  endtask

  // Called at a negedge in an IDLE cycle; returns at the negedge of the following IDLE cycle.
  task automatic do_txn(input logic [NREQ-1:0] reqv, input int waits,
                        input logic [DW-1:0] din_v, input logic drop_mid);
    int w;
    drive_reqs(reqv);
    w = model_pick(reqv);
    @(posedge CLK); #1;
    check("gnt", 32'(GNT), 32'(1) << w);
    check("gnt_id", 32'(GNT_ID), 32'(w));
    check("mem_addr", 32'(MEM_ADDR), 32'(addr_a[w]));
    check("mem_rd", 32'(MEM_RD), 32'(!wr_a[w]));
    check("mem_wr", 32'(MEM_WR), 32'(wr_a[w]));
    if (wr_a[w]) check("mem_dout", 32'(MEM_DOUT), 32'(wdata_a[w]));
    if (drop_mid) REQ = '0;
    for (int i = 0; i < waits; i++) begin
      @(negedge CLK);
      MEM_READY = 1'b0;
      MEM_DIN   = DW'($urandom);
      @(posedge CLK); #1;
      check("hold_strobe", {30'd0, MEM_RD, MEM_WR}, {30'd0, !wr_a[w], wr_a[w]});
      check("hold_ack", 32'(ACK), 32'd0);
    end
    @(negedge CLK);
    MEM_READY = 1'b1;
    MEM_DIN   = din_v;
    @(posedge CLK); #1;
    check("ack", 32'(ACK), 32'(1) << w);
    check("rdata", 32'(RDATA), wr_a[w] ? 32'd0 : 32'(din_v));
    check("err", 32'(ERR), 32'd0);
    check("done_strobes", {30'd0, MEM_RD, MEM_WR}, 32'd0);
    check("done_gnt", 32'(GNT), 32'(1) << w);
    @(negedge CLK);
    MEM_READY = 1'b0;
    @(posedge CLK); #1;
    check("ack_clr", 32'(ACK), 32'd0);
    check("gnt_clr", 32'(GNT), 32'd0);
    @(negedge CLK);
  endtask

  task automatic idle_cycle();
    @(posedge CLK); #1;
    check("idle_gnt", 32'(GNT), 32'd0);
    check("idle_strobes", {30'd0, MEM_RD, MEM_WR}, 32'd0);
    @(negedge CLK);
  endtask

  initial begin
    RESETN    = 1'b1;
    REQ       = '0;
    REQ_WR    = '0;
    REQ_ADDR  = '0;
    REQ_WDATA = '0;
    MEM_DIN   = '0;
    MEM_READY = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i] = '0; wdata_a[i] = '0; wr_a[i] = 1'b0;
    end
    model_reset();
    #12;
    check("rst_gnt", 32'(GNT), 32'd0);
    check("rst_ack", 32'(ACK), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_rdata", 32'(RDATA), 32'd0);
    check("rst_gnt_id", 32'(GNT_ID), 32'd0);
    check("rst_addr_dout", {MEM_ADDR, MEM_DOUT}, 32'd0);
    check("rst_strobes", {30'd0, MEM_RD, MEM_WR}, 32'd0);
    @(negedge CLK);
    RESETN = 1'b0;

    // Asynchronous reset in the middle of an access.
    addr_a[REQ_FETCH] = 16'h0100;
    wr_a[REQ_FETCH]   = 1'b0;
    drive_reqs(3'b001);
    @(posedge CLK); #1;
    check("pre_rst_rd", 32'(MEM_RD), 32'd1);
    #2 RESETN = 1'b1;
    #1;
    check("mid_rst_rd", 32'(MEM_RD), 32'd0);
    check("mid_rst_gnt", 32'(GNT), 32'd0);
    check("mid_rst_ack", 32'(ACK), 32'd0);
    REQ = '0;
    @(negedge CLK);
    RESETN = 1'b0;
    model_reset();
    do_txn(3'b111, 0, 16'h5a5a, 1'b0);
    check("first_after_rst", 32'(GNT_ID), 32'(REQ_FETCH));

    // Zero-wait read by the load/store port.
    addr_a[REQ_LS] = 16'h1234;
    wr_a[REQ_LS]   = 1'b0;
    do_txn(3'b010, 0, 16'hBEEF, 1'b0);

    // Write with three wait states by the external port.
    addr_a[REQ_EXT]  = 16'h4000;
    wdata_a[REQ_EXT] = 16'h00A5;
    wr_a[REQ_EXT]    = 1'b1;
    do_txn(3'b100, 3, 16'hFFFF, 1'b0);

    // All requesters held high: grants rotate.
    for (int t = 0; t < 9; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        addr_a[i] = AW'($urandom); wdata_a[i] = DW'($urandom); wr_a[i] = 1'($urandom);
      end
      do_txn(3'b111, 0, DW'($urandom), 1'b0);
      check("rotate_id", 32'(GNT_ID), 32'(t % NREQ));
    end

    // Fetch drops REQ mid-access: completes, no extra grant.
    wr_a[REQ_FETCH] = 1'b0;
    do_txn(3'b001, 2, 16'h1111, 1'b1);
    idle_cycle();
    idle_cycle();

    // Randomized traffic.
    for (int t = 0; t < 80; t++) begin
      logic [NREQ-1:0] rv;
      for (int i = 0; i < NREQ; i++) begin
        addr_a[i] = AW'($urandom); wdata_a[i] = DW'($urandom); wr_a[i] = 1'($urandom);
      end
      rv = NREQ'($urandom_range(0, 7));
      if (rv == '0) begin
        drive_reqs('0);
        idle_cycle();
      end else begin
        do_txn(rv, int'($urandom_range(0, 4)), DW'($urandom), $urandom_range(0, 3) == 0);
      end
    end

    // Slave never ready.
    wr_a[REQ_FETCH] = 1'b0;
    drive_reqs(3'b001);
    void'(model_pick(3'b001));
    @(posedge CLK); #1;
    check("stuck_rd", 32'(MEM_RD), 32'd1);
`ifdef MEM_BUS_TIMEOUT_EN
    n_to = 0;
    while (ACK == '0 && n_to < 40) begin
      @(posedge CLK); #1;
      n_to++;
    end
    check("to_cycles", 32'(n_to), 32'(WAIT_MAX_DEFAULT + 1));
    check("to_ack", 32'(ACK), 32'd1);
    check("to_err", 32'(ERR), 32'd1);
    check("to_rdata", 32'(RDATA), 32'd0);
    check("to_strobes", {30'd0, MEM_RD, MEM_WR}, 32'd0);
`else
    seen_ack = 1'b0;
    n_to = 0;
    repeat (100) begin
      @(posedge CLK); #1;
      if (ACK != '0) seen_ack = 1'b1;
    end
    check("no_ack", 32'(seen_ack), 32'd0);
    check("still_rd", 32'(MEM_RD), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
